// File: rtl/cache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// cache_flush_ctrl
//
// Sequencer for the bulk tag-store operations of one cache bank.
//
//   * After reset it sweeps every line with tag_init asserted (one line per
//     cycle, ignoring pipeline back-pressure).
//   * On an accepted flush request it either
//       - WRITEBACK=1: waits for the core misses to drain, then issues one
//         flush op per (line, way) through the bank pipeline, waits for the
//         writebacks those ops caused, and reports completion; or
//       - WRITEBACK=0: reruns the init sweep as a plain invalidate and
//         reports completion when it ends.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   flush_req_valid/_ready   flush request handshake (ready only in IDLE)
//   flush_done_valid/_ready  completion handshake (valid held until ready)
//   init_busy          an init or invalidate sweep is running
//   mshr_empty         no core misses outstanding in the bank
//   pipe_ready         bank pipeline takes a flush op this cycle
//   wb_pending         memory writebacks still outstanding
//   tag_init           tag store init strobe
//   tag_flush          tag store flush_line strobe
//   tag_way_sel        one-hot way select for the flush op
//   tag_line_sel       line index for the init / flush op
// ---------------------------------------------------------------------------
module cache_flush_ctrl #(
    parameter int NUM_LINES     = 64,
    parameter int NUM_WAYS      = 1,
    parameter int WRITEBACK     = 0,
    parameter int LINE_SEL_BITS = $clog2(NUM_LINES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_req_valid,
    output logic                     flush_req_ready,
    output logic                     flush_done_valid,
    input  logic                     flush_done_ready,
    output logic                     init_busy,
    input  logic                     mshr_empty,
    input  logic                     pipe_ready,
    input  logic                     wb_pending,
    output logic                     tag_init,
    output logic                     tag_flush,
    output logic [NUM_WAYS-1:0]      tag_way_sel,
    output logic [LINE_SEL_BITS-1:0] tag_line_sel
);

    // A one-way bank still needs a legal vector width for the way index;
    // it is tied to zero in that case and no counter is built.
    localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_DRAIN   = 3'd2,
        S_FLUSH   = 3'd3,
        S_WAIT_WB = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                   state_reg;
    state_t                   state_next;

    // Set while the INIT sweep is an invalidate requested by a flush, so
    // that the sweep ends in DONE rather than IDLE.
    logic                     inval_reg;
    logic                     inval_next;

    logic [LINE_SEL_BITS-1:0] line_reg;
    logic [WAY_BITS-1:0]      way_idx;

    logic                     line_last;
    logic                     way_last;
    logic                     req_accept;
    logic                     op_accept;
    logic                     line_adv;

    assign line_last  = (line_reg == LINE_SEL_BITS'(NUM_LINES - 1));
    assign way_last   = (way_idx == WAY_BITS'(NUM_WAYS - 1));
    assign req_accept = (state_reg == S_IDLE) && flush_req_valid;
    assign op_accept  = (state_reg == S_FLUSH) && pipe_ready;

    // The line moves every INIT cycle, and in FLUSH only once the last way
    // of the current line has been accepted (line-major, way-minor order).
    assign line_adv   = (state_reg == S_INIT) || (op_accept && way_last);

    // -----------------------------------------------------------------------
    // Counters. Both are powers of two wide, so they wrap back to zero on the
    // final increment of a sweep; every sweep therefore starts from zero
    // without an explicit clear.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_reg <= '0;
        end else if (line_adv) begin
            line_reg <= line_reg + LINE_SEL_BITS'(1);
        end
    end

    generate
        if (NUM_WAYS > 1) begin : g_way_cnt
            logic [WAY_BITS-1:0] way_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    way_reg <= '0;
                end else if (op_accept) begin
                    way_reg <= way_reg + WAY_BITS'(1);
                end
            end

            assign way_idx = way_reg;
        end else begin : g_no_way_cnt
            assign way_idx = '0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_INIT;
            inval_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            inval_reg <= inval_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        inval_next = inval_reg;

        case (state_reg)
            S_INIT: begin
                if (line_last) begin
                    state_next = inval_reg ? S_DONE : S_IDLE;
                    inval_next = 1'b0;
                end
            end

            S_IDLE: begin
                if (req_accept) begin
                    if (WRITEBACK != 0) begin
                        state_next = S_DRAIN;
                    end else begin
                        state_next = S_INIT;
                        inval_next = 1'b1;
                    end
                end
            end

            // Flush ops must not race in-flight core misses for the same
            // lines, so nothing is issued until the MSHRs are empty.
            S_DRAIN: begin
                if (mshr_empty) begin
                    state_next = S_FLUSH;
                end
            end

            S_FLUSH: begin
                if (op_accept && way_last && line_last) begin
                    state_next = S_WAIT_WB;
                end
            end

            // Completion is only meaningful once the evictions we caused
            // have reached memory.
            S_WAIT_WB: begin
                if (!wb_pending) begin
                    state_next = S_DONE;
                end
            end

            S_DONE: begin
                if (flush_done_ready) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_INIT;
                inval_next = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic (Moore: depends on state and counters only, so a stalled
    // flush op holds perfectly still while pipe_ready is low)
    // -----------------------------------------------------------------------
    always_comb begin
        flush_req_ready  = 1'b0;
        flush_done_valid = 1'b0;
        init_busy        = 1'b0;
        tag_init         = 1'b0;
        tag_flush        = 1'b0;
        tag_way_sel      = '0;
        tag_line_sel     = '0;

        case (state_reg)
            S_INIT: begin
                init_busy    = 1'b1;
                tag_init     = 1'b1;
                tag_line_sel = line_reg;
            end

            S_IDLE: begin
                flush_req_ready = 1'b1;
            end

            S_FLUSH: begin
                tag_flush    = 1'b1;
                tag_line_sel = line_reg;
                tag_way_sel  = NUM_WAYS'(1) << way_idx;
            end

            S_DONE: begin
                flush_done_valid = 1'b1;
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for cache_flush_ctrl. Two instances share the clock:
//   u_wb  : NUM_LINES=4, NUM_WAYS=2, WRITEBACK=1 (flush sweeps)
//   u_inv : NUM_LINES=4, NUM_WAYS=1, WRITEBACK=0 (invalidate sweep)
// Expected flush traffic is an ordered queue of (line, way) pairs built from
// nested loops; each accepted op pops the queue head.
// ---------------------------------------------------------------------------
module tb_cache_flush_ctrl;

    localparam int NL = 4;
    localparam int NW = 2;

    int n_checks = 0;
    int n_errors = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush_req_valid = 1'b0;
    logic       flush_req_ready;
    logic       flush_done_valid;
    logic       flush_done_ready = 1'b0;
    logic       init_busy;
    logic       mshr_empty = 1'b1;
    logic       pipe_ready = 1'b0;
    logic       wb_pending = 1'b0;
    logic       tag_init;
    logic       tag_flush;
    logic [1:0] tag_way_sel;
    logic [1:0] tag_line_sel;

    logic       inv_reset = 1'b1;
    logic       inv_req_valid = 1'b0;
    logic       inv_req_ready;
    logic       inv_done_valid;
    logic       inv_done_ready = 1'b0;
    logic       inv_init_busy;
    logic       inv_tag_init;
    logic       inv_tag_flush;
    logic [0:0] inv_way_sel;
    logic [1:0] inv_line_sel;

    always #5 clk = ~clk;

    cache_flush_ctrl #(.NUM_LINES(NL), .NUM_WAYS(NW), .WRITEBACK(1)) u_wb (
        .clk              (clk),
        .reset            (reset),
        .flush_req_valid  (flush_req_valid),
        .flush_req_ready  (flush_req_ready),
        .flush_done_valid (flush_done_valid),
        .flush_done_ready (flush_done_ready),
        .init_busy        (init_busy),
        .mshr_empty       (mshr_empty),
        .pipe_ready       (pipe_ready),
        .wb_pending       (wb_pending),
        .tag_init         (tag_init),
        .tag_flush        (tag_flush),
        .tag_way_sel      (tag_way_sel),
        .tag_line_sel     (tag_line_sel)
    );

    cache_flush_ctrl #(.NUM_LINES(NL), .NUM_WAYS(1), .WRITEBACK(0)) u_inv (
        .clk              (clk),
        .reset            (inv_reset),
        .flush_req_valid  (inv_req_valid),
        .flush_req_ready  (inv_req_ready),
        .flush_done_valid (inv_done_valid),
        .flush_done_ready (inv_done_ready),
        .init_busy        (inv_init_busy),
        .mshr_empty       (1'b1),
        .pipe_ready       (1'b1),
        .wb_pending       (1'b0),
        .tag_init         (inv_tag_init),
        .tag_flush        (inv_tag_flush),
        .tag_way_sel      (inv_way_sel),
        .tag_line_sel     (inv_line_sel)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        n_errors++;
        $error("FAIL %s", tag);
    endtask

    // NL cycles of init on u_wb, starting from line 0, then IDLE.
    task automatic check_init_sweep(input string name);
        logic [1:0] exp_line;
        for (int i = 0; i < NL; i++) begin
            exp_line = i[1:0];
            n_checks++;
            if (tag_init !== 1'b1) fail("init_tag_init");
            n_checks++;
            if (tag_line_sel !== exp_line) fail("init_line_sel");
            n_checks++;
            if (init_busy !== 1'b1) fail("init_busy");
            n_checks++;
            if (flush_req_ready !== 1'b0) fail("init_req_ready");
            n_checks++;
            if (tag_flush !== 1'b0) fail("init_tag_flush");
            step();
        end
        n_checks++;
        if (flush_req_ready !== 1'b1) fail("init_end_ready");
        n_checks++;
        if (tag_init !== 1'b0) fail("init_end_tag_init");
        n_checks++;
        if (init_busy !== 1'b0) fail("init_end_busy");
        $display("init sweep (%s): %0d lines", name, NL);
    endtask

    // One complete flush transaction on u_wb, starting in IDLE.
    // pipe_mode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    task automatic run_flush(input int mshr_delay, input int wb_delay,
                             input int done_delay, input int pipe_mode);
        int         ql[$];
        int         qw[$];
        int         budget;
        int         pat;
        int         accepts;
        int         stalls;
        logic [1:0] exp_line;
        logic [1:0] exp_way;
        logic [1:0] one_hot;

        for (int l = 0; l < NL; l++) begin
            for (int w = 0; w < NW; w++) begin
                ql.push_back(l);
                qw.push_back(w);
            end
        end

        flush_req_valid = 1'b1;
        mshr_empty      = (mshr_delay == 0);
        wb_pending      = (wb_delay > 0);
        pipe_ready      = 1'b0;
        chk("idle_req_ready", flush_req_ready, 1'b1);
        step();
        flush_req_valid = 1'b0;

        for (int k = 0; k < mshr_delay; k++) begin
            n_checks++;
            if (tag_flush !== 1'b0) fail("drain_no_flush");
            n_checks++;
            if (flush_req_ready !== 1'b0) fail("drain_no_ready");
            step();
        end
        mshr_empty = 1'b1;
        chk("drain_last_no_flush", tag_flush, 1'b0);
        step();

        budget  = 0;
        pat     = 0;
        accepts = 0;
        stalls  = 0;
        while (ql.size() > 0 && budget < 200) begin
            case (pipe_mode)
                0:       pipe_ready = 1'b1;
                1:       pipe_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
                default: pipe_ready = 1'($urandom_range(0, 1));
            endcase
            pat++;
            exp_line = ql[0][1:0];
            one_hot  = 2'b01;
            exp_way  = one_hot << qw[0];
            n_checks++;
            if (tag_flush !== 1'b1) fail("flush_tag_flush");
            n_checks++;
            if (tag_line_sel !== exp_line) fail("flush_line_sel");
            n_checks++;
            if (tag_way_sel !== exp_way) fail("flush_way_sel");
            n_checks++;
            if (tag_init !== 1'b0) fail("flush_tag_init");
            if (pipe_ready) begin
                void'(ql.pop_front());
                void'(qw.pop_front());
                accepts++;
            end else begin
                stalls++;
            end
            step();
            budget++;
        end
        pipe_ready = 1'b0;
        chk("flush_accepts", accepts, NL * NW);

        for (int k = 0; k < wb_delay; k++) begin
            n_checks++;
            if (tag_flush !== 1'b0) fail("wait_no_flush");
            n_checks++;
            if (tag_way_sel !== 2'b00) fail("wait_way_sel");
            n_checks++;
            if (flush_done_valid !== 1'b0) fail("wait_no_done");
            step();
        end
        wb_pending = 1'b0;
        chk("wait_last_no_done", flush_done_valid, 1'b0);
        chk("wait_last_no_flush", tag_flush, 1'b0);
        step();

        for (int k = 0; k < done_delay; k++) begin
            flush_done_ready = 1'b0;
            n_checks++;
            if (flush_done_valid !== 1'b1) fail("done_valid_held");
            n_checks++;
            if (flush_req_ready !== 1'b0) fail("done_no_req_ready");
            step();
        end
        flush_done_ready = 1'b1;
        chk("done_valid", flush_done_valid, 1'b1);
        step();
        flush_done_ready = 1'b0;
        chk("back_idle_ready", flush_req_ready, 1'b1);
        chk("back_idle_done", flush_done_valid, 1'b0);
        $display("flush: mshr_delay=%0d wb_delay=%0d done_delay=%0d pipe_mode=%0d accepts=%0d stalls=%0d",
                 mshr_delay, wb_delay, done_delay, pipe_mode, accepts, stalls);
    endtask

    initial begin
        logic [1:0] exp_line;

        // Reset values
        step();
        step();
        chk("rst_req_ready", flush_req_ready, 1'b0);
        chk("rst_done_valid", flush_done_valid, 1'b0);
        chk("rst_tag_flush", tag_flush, 1'b0);
        chk("rst_way_sel", tag_way_sel, 2'b00);
        chk("rst_tag_init", tag_init, 1'b1);
        chk("rst_init_busy", init_busy, 1'b1);
        chk("rst_line_sel", tag_line_sel, 2'b00);
        $display("reset: outputs checked");

        // A request raised during init stays pending until IDLE.
        reset           = 1'b0;
        flush_req_valid = 1'b1;
        check_init_sweep("power-on");

        run_flush(0, 0, 0, 0);
        run_flush(0, 0, 0, 1);
        run_flush(5, 3, 2, 0);
        for (int r = 0; r < 4; r++) begin
            run_flush(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 2);
        end

        // Reset in the middle of a flush, after five ops.
        flush_req_valid = 1'b1;
        mshr_empty      = 1'b1;
        step();
        flush_req_valid = 1'b0;
        step();
        pipe_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        n_checks++;
        if (tag_flush !== 1'b1) fail("mid_flush_active");
        reset = 1'b1;
        #1;
        n_checks++;
        if (tag_flush !== 1'b0) fail("mid_rst_tag_flush");
        n_checks++;
        if (tag_init !== 1'b1) fail("mid_rst_tag_init");
        n_checks++;
        if (tag_line_sel !== 2'b00) fail("mid_rst_line_sel");
        n_checks++;
        if (tag_way_sel !== 2'b00) fail("mid_rst_way_sel");
        pipe_ready = 1'b0;
        step();
        reset = 1'b0;
        check_init_sweep("after mid-flush reset");
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (flush_done_valid !== 1'b0) fail("abandoned_no_done");
            n_checks++;
            if (flush_req_ready !== 1'b1) fail("abandoned_idle");
            step();
        end
        $display("mid-flush reset: sweep abandoned");

        // Invalidate-only variant
        inv_reset = 1'b0;
        for (int k = 0; k < NL; k++) step();
        chk("inv_idle_ready", inv_req_ready, 1'b1);
        inv_req_valid = 1'b1;
        step();
        inv_req_valid = 1'b0;
        for (int i = 0; i < NL; i++) begin
            exp_line = i[1:0];
            n_checks++;
            if (inv_tag_init !== 1'b1) fail("inv_tag_init");
            n_checks++;
            if (inv_line_sel !== exp_line) fail("inv_line_sel");
            n_checks++;
            if (inv_init_busy !== 1'b1) fail("inv_busy");
            n_checks++;
            if (inv_tag_flush !== 1'b0) fail("inv_no_flush");
            n_checks++;
            if (inv_done_valid !== 1'b0) fail("inv_no_done");
            step();
        end
        n_checks++;
        if (inv_done_valid !== 1'b1) fail("inv_done_valid");
        n_checks++;
        if (inv_tag_init !== 1'b0) fail("inv_end_init");
        n_checks++;
        if (inv_init_busy !== 1'b0) fail("inv_end_busy");
        inv_done_ready = 1'b1;
        step();
        inv_done_ready = 1'b0;
        n_checks++;
        if (inv_req_ready !== 1'b1) fail("inv_back_idle");
        n_checks++;
        if (inv_done_valid !== 1'b0) fail("inv_done_clear");
        $display("invalidate: %0d-line sweep then done", NL);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
